// File: rtl/mxu_sequencer.sv
// Job sequencer for an NxN systolic array: loads N weight rows, streams R input rows,
// drains the skew pipeline, then pulses done. Define MXU_SEQ_PERF_CNT_EN to add perf_cycles.
module mxu_sequencer #(
  parameter int N  = 32,
  parameter int RW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RW-1:0]        num_rows,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 w_load,
  output logic [$clog2(N)-1:0] w_addr,
  output logic                 feed_en,
  output logic [RW-1:0]        feed_row,
  output logic                 acc_clear,
  output logic                 out_valid,
  output logic [RW-1:0]        out_row
`ifdef MXU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int AW = $clog2(N);
  // Wide enough for t = R + 2N - 2 with R = 2^RW - 1, and never narrower than RW+1.
  localparam int TW = ((RW > AW + 1) ? RW : AW + 1) + 1;
  localparam logic [TW-1:0] LOAD_LAST = TW'(N - 1);
  localparam logic [TW-1:0] OUT_FIRST = TW'(2 * N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   r_q, r_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            w_load_q, w_load_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic            feed_en_q, feed_en_d;
  logic [RW-1:0]   feed_row_q, feed_row_d;
  logic            acc_clear_q, acc_clear_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_row_q, out_row_d;

  logic [TW-1:0]   r_last;
  logic [TW-1:0]   drain_last;

  assign r_last     = TW'(r_q) - TW'(1);
  assign drain_last = TW'(r_q) + TW'(2 * N - 2);

  // In LOAD_W cnt is the weight row; from the first STREAM cycle on it is t.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_rows == '0) begin
            state_d = DONE;
          end else begin
            r_d     = num_rows;
            cnt_d   = '0;
            state_d = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (cnt_q == r_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == drain_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register matches state_q after the edge.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    w_load_d    = 1'b0;
    acc_clear_d = 1'b0;
    feed_en_d   = 1'b0;
    out_valid_d = 1'b0;
    out_row_d   = '0;
    w_addr_d    = w_addr_q;
    feed_row_d  = feed_row_q;
    case (state_d)
      LOAD_W: begin
        busy_d      = 1'b1;
        w_load_d    = 1'b1;
        w_addr_d    = cnt_d[AW-1:0];
        acc_clear_d = (cnt_d == '0);
      end
      STREAM, DRAIN: begin
        busy_d      = 1'b1;
        feed_en_d   = 1'b1;
        feed_row_d  = (state_d == STREAM) ? cnt_d[RW-1:0] : (r_q - RW'(1));
        out_valid_d = (cnt_d >= OUT_FIRST);
        if (cnt_d >= OUT_FIRST) out_row_d = RW'(cnt_d - OUT_FIRST);
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_load_q    <= 1'b0;
      w_addr_q    <= '0;
      feed_en_q   <= 1'b0;
      feed_row_q  <= '0;
      acc_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_load_q    <= w_load_d;
      w_addr_q    <= w_addr_d;
      feed_en_q   <= feed_en_d;
      feed_row_q  <= feed_row_d;
      acc_clear_q <= acc_clear_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_load    = w_load_q;
  assign w_addr    = w_addr_q;
  assign feed_en   = feed_en_q;
  assign feed_row  = feed_row_q;
  assign acc_clear = acc_clear_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;

`ifdef MXU_SEQ_PERF_CNT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] perf_q, perf_d;

  // run_cnt holds the busy cycles seen so far; it is captured only on a real entry to DONE.
  always_comb begin
    run_cnt_d = busy_d ? (run_cnt_q + 32'd1) : 32'd0;
    perf_d    = perf_q;
    if (state_d == DONE && state_q != DONE) perf_d = run_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      perf_q    <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      perf_q    <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer: cycle-accurate job timing, abort, reset and a row scoreboard.
`timescale 1ns/1ps
module tb_mxu_sequencer;
  localparam int N  = 32;
  localparam int RW = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic          busy, done, w_load, feed_en, acc_clear, out_valid;
  logic [AW-1:0] w_addr;
  logic [RW-1:0] feed_row, out_row;
`ifdef MXU_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  longint last_perf = 0;

  always #5 clk = ~clk;

  mxu_sequencer #(.N(N), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .w_load    (w_load),
    .w_addr    (w_addr),
    .feed_en   (feed_en),
    .feed_row  (feed_row),
    .acc_clear (acc_clear),
    .out_valid (out_valid),
    .out_row   (out_row)
`ifdef MXU_SEQ_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag, input longint exp);
`ifdef MXU_SEQ_PERF_CNT_EN
    check(tag, 64'(perf_cycles), 64'(exp));
    $display("perf %s: perf_cycles=%0d", tag, perf_cycles);
`endif
  endtask

  // Scoreboard: every presented result row must match the next expected row index.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", 64'(out_row), 64'hFFFF);
      else check("out_row", 64'(out_row), 64'(exp_q.pop_front()));
    end
  end

  task automatic start_job(input int r, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    start    = 1'b1;
    num_rows = RW'(r);
    for (int i = 0; i < r; i++) exp_q.push_back(i);
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_rows = ~RW'(r);
  endtask

  // Watches one complete job, cycle 1 being the cycle after start was accepted.
  task automatic observe(input int r, input int pulse_k, input string tag);
    int wl_first = -1, wl_last = -1, fe_first = -1, fe_last = -1;
    int ov_first = -1, ov_last = -1, done_k = -1, ndone = 0;
    int nclr = 0, clr_k = -1, bad_addr = 0, bad_row = 0, bad_busy = 0, exp_row;
    int budget = 3 * N + r + 8;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == pulse_k) begin
        start = 1'b1;
        num_rows = RW'(7);
      end else if (k == pulse_k + 1) begin
        start = 1'b0;
      end
      if (w_load) begin
        if (wl_first < 0) wl_first = k;
        wl_last = k;
        if (w_addr !== AW'(k - 1)) bad_addr++;
      end
      if (feed_en) begin
        if (fe_first < 0) fe_first = k;
        fe_last = k;
        exp_row = (k - (N + 1) < r - 1) ? k - (N + 1) : r - 1;
        if (feed_row !== RW'(exp_row)) bad_row++;
      end
      if (out_valid) begin
        if (ov_first < 0) ov_first = k;
        ov_last = k;
      end
      if (acc_clear) begin
        nclr++;
        clr_k = k;
      end
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (busy !== (k <= 3 * N + r - 1)) bad_busy++;
    end
    $display("job %s R=%0d: w_load %0d-%0d feed %0d-%0d valid %0d-%0d done@%0d",
             tag, r, wl_first, wl_last, fe_first, fe_last, ov_first, ov_last, done_k);
    check({tag, ".wl_first"}, 64'(wl_first), 64'(1));
    check({tag, ".wl_last"},  64'(wl_last),  64'(N));
    check({tag, ".fe_first"}, 64'(fe_first), 64'(N + 1));
    check({tag, ".fe_last"},  64'(fe_last),  64'(3 * N + r - 1));
    check({tag, ".ov_first"}, 64'(ov_first), 64'(3 * N));
    check({tag, ".ov_last"},  64'(ov_last),  64'(3 * N + r - 1));
    check({tag, ".done_k"},   64'(done_k),   64'(3 * N + r));
    check({tag, ".ndone"},    64'(ndone),    64'(1));
    check({tag, ".nclr"},     64'(nclr),     64'(1));
    check({tag, ".clr_k"},    64'(clr_k),    64'(1));
    check({tag, ".bad_addr"}, 64'(bad_addr), 64'(0));
    check({tag, ".bad_row"},  64'(bad_row),  64'(0));
    check({tag, ".bad_busy"}, 64'(bad_busy), 64'(0));
    check({tag, ".w_addr_hold"},   64'(w_addr),   64'(N - 1));
    check({tag, ".feed_row_hold"}, 64'(feed_row), 64'(r - 1));
    check({tag, ".queue_empty"},   64'(exp_q.size()), 64'(0));
    check_perf({tag, ".perf"}, 3 * N + r - 1);
    last_perf = 3 * N + r - 1;
  endtask

  // Counts done pulses and busy cycles over a window where no job should run.
  task automatic expect_quiet(input int cycles, input string tag);
    int nd = 0, nb = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy || w_load || feed_en || acc_clear || out_valid) nb++;
    end
    $display("quiet %s: %0d cycles, done=%0d active=%0d", tag, cycles, nd, nb);
    check({tag, ".no_done"},   64'(nd), 64'(0));
    check({tag, ".no_active"}, 64'(nb), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, bad;
    #12;
    check("reset_outputs", {busy, done, w_load, feed_en, acc_clear, out_valid, w_addr, feed_row, out_row}, '0);
    check_perf("reset_perf", 0);

    // Normal job accepted on the first edge after reset release.
    start_job(4, 1'b1);
    observe(4, -1, "r4");

    // Abort at STREAM t=2 (cycle N+3).
    start_job(10, 1'b0);
    repeat (N + 3) @(negedge clk);
    check("abort.pre_feed_row", 64'(feed_row), 64'(2));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.outputs", {busy, done, w_load, feed_en, acc_clear, out_valid}, '0);
    exp_q.delete();
    expect_quiet(3 * N, "abort");
    check_perf("abort.perf_kept", last_perf);
    start_job(3, 1'b0);
    observe(3, -1, "after_abort");

    // Zero-row job: done in cycle 1, nothing else.
    start_job(0, 1'b0);
    nd = 0;
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done !== (k == 1)) nd++;
      if (busy || w_load || feed_en || acc_clear || out_valid) bad++;
    end
    $display("job zero: done errors=%0d active=%0d", nd, bad);
    check("zero.done_timing", 64'(nd), 64'(0));
    check("zero.no_activity", 64'(bad), 64'(0));
    check_perf("zero.perf", 0);
    last_perf = 0;

    // Start pulsed while busy must be ignored.
    start_job(4, 1'b0);
    observe(4, 40, "restart_ignored");

    // Largest row count.
    start_job(255, 1'b0);
    observe(255, -1, "r255");

    // Abort has priority over start in IDLE.
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    num_rows = RW'(5);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_vs_start.busy", 64'(busy), 64'(0));
    expect_quiet(4, "abort_vs_start");

    // Asynchronous reset mid-DRAIN.
    start_job(4, 1'b0);
    repeat (50) @(negedge clk);
    check("rst_mid.pre_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", {busy, done, w_load, feed_en, acc_clear, out_valid, w_addr, feed_row, out_row}, '0);
    check_perf("rst_mid.perf", 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(3 * N + 10, "rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
